// File: rtl/upc_serial_tx.sv
// Serialises a captured UPC code and security mark as one framed, odd-parity word, MSB first.
// One frame in flight; tx/done are registered, and ready is high only while idle.
module upc_serial_tx #(
  parameter int UPC_W      = 3,
  parameter int BIT_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [UPC_W-1:0] upc,
  input  logic             mark,
  output logic             ready,
  output logic             tx,
  output logic             done
);

  localparam int SW = UPC_W + 2;
  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int IW = (UPC_W > 1) ? $clog2(UPC_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_MARK, S_PARITY, S_STOP
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [SW-1:0]   shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;
  logic            bit_last;

  assign bit_last = (cnt_q == CW'(BIT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  // The shift register holds {upc, mark, parity}; tx is loaded with the bit
  // the next state will present, so it changes on the same edge as the state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    if (state_q != S_IDLE) begin
      cnt_d = bit_last ? '0 : cnt_q + 1'b1;
    end
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
        if (start) begin
          shift_d = {upc, mark, ~^{upc, mark}};
          state_d = S_START;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (bit_last) begin
          state_d = S_DATA;
          idx_d   = IW'(UPC_W - 1);
          tx_d    = shift_q[SW-1];
        end
      end
      S_DATA: begin
        if (bit_last) begin
          shift_d = shift_q << 1;
          tx_d    = shift_q[SW-2];
          if (idx_q == '0) begin
            state_d = S_MARK;
          end else begin
            idx_d = idx_q - 1'b1;
          end
        end
      end
      S_MARK: begin
        if (bit_last) begin
          shift_d = shift_q << 1;
          tx_d    = shift_q[SW-2];
          state_d = S_PARITY;
        end
      end
      S_PARITY: begin
        if (bit_last) begin
          shift_d = shift_q << 1;
          tx_d    = 1'b1;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (bit_last) begin
          state_d = S_IDLE;
          idx_d   = '0;
          tx_d    = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  assign ready = (state_q == S_IDLE);
  assign tx    = tx_q;
  assign done  = done_q;

endmodule

// File: tb/tb_upc_serial_tx.sv
// Directed bench for upc_serial_tx: expected frame bits are queued when a start is
// driven and popped as each serial bit is observed, on a 4-cycle and a 1-cycle instance.
module tb_upc_serial_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       start4, start1;
  logic [2:0] upc;
  logic       mark;
  logic       ready4, tx4, done4;
  logic       ready1, tx1, done1;

  int n_tests = 0;
  int n_fail  = 0;
  logic exp_q[$];
  bit   ab;

  always #5 clk = ~clk;

  upc_serial_tx #(.UPC_W(3), .BIT_CYCLES(4)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .upc(upc), .mark(mark),
    .ready(ready4), .tx(tx4), .done(done4)
  );

  upc_serial_tx #(.UPC_W(3), .BIT_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .upc(upc), .mark(mark),
    .ready(ready1), .tx(tx1), .done(done1)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Frame: START, upc MSB..LSB, mark, odd parity over {upc,mark,parity}, STOP.
  task automatic push_frame(input logic [2:0] u, input logic m);
    logic par;
    par = ~(u[2] ^ u[1] ^ u[0] ^ m);
    exp_q.push_back(1'b0);
    exp_q.push_back(u[2]);
    exp_q.push_back(u[1]);
    exp_q.push_back(u[0]);
    exp_q.push_back(m);
    exp_q.push_back(par);
    exp_q.push_back(1'b1);
  endtask

  task automatic idle_chk(input string tag);
    chk({tag, " ready4"}, ready4, 1'b1);
    chk({tag, " tx4"},    tx4,    1'b1);
    chk({tag, " done4"},  done4,  1'b0);
  endtask

  // Called at the negedge of the first START cycle. act: 1 = change upc to 111,
  // 2 = pulse start4 for one cycle, 3 = assert reset (frame abandoned).
  task automatic run_frame(input int bc, input int act_cyc, input int act, output bit aborted);
    logic e, t, r, d;
    int   k;
    aborted = 1'b0;
    for (int b = 0; b < 7; b++) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard empty", 1'b1, 1'b0);
        e = 1'bx;
      end else begin
        e = exp_q.pop_front();
      end
      for (int c = 0; c < bc; c++) begin
        k = b * bc + c;
        if (k != 0) @(negedge clk);
        t = (bc == 1) ? tx1 : tx4;
        r = (bc == 1) ? ready1 : ready4;
        d = (bc == 1) ? done1 : done4;
        chk($sformatf("bc%0d bit%0d cyc%0d tx", bc, b, k), t, e);
        chk($sformatf("bc%0d cyc%0d ready", bc, k), r, 1'b0);
        chk($sformatf("bc%0d cyc%0d done", bc, k), d, 1'b0);
        if (act == 2 && k == act_cyc + 1) start4 = 1'b0;
        if (k == act_cyc) begin
          case (act)
            1: upc = 3'b111;
            2: start4 = 1'b1;
            3: begin
              reset = 1'b0;
              #1;
              chk("async reset tx", tx4, 1'b1);
              chk("async reset ready", ready4, 1'b1);
              chk("async reset done", done4, 1'b0);
              exp_q.delete();
              aborted = 1'b1;
              return;
            end
            default: ;
          endcase
        end
      end
    end
    @(negedge clk);
    t = (bc == 1) ? tx1 : tx4;
    r = (bc == 1) ? ready1 : ready4;
    d = (bc == 1) ? done1 : done4;
    chk($sformatf("bc%0d end done", bc), d, 1'b1);
    chk($sformatf("bc%0d end ready", bc), r, 1'b1);
    chk($sformatf("bc%0d end tx", bc), t, 1'b1);
  endtask

  initial begin
    reset  = 1'b1;
    start4 = 1'b0;
    start1 = 1'b0;
    upc    = 3'b000;
    mark   = 1'b0;
    #2 reset = 1'b0;

    // 1: reset and idle
    repeat (2) @(negedge clk);
    idle_chk("in reset");
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      idle_chk($sformatf("idle%0d", i));
    end

    // 2: 101 / mark=1
    upc = 3'b101; mark = 1'b1;
    push_frame(upc, mark);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    run_frame(4, -1, 0, ab);
    @(negedge clk);
    idle_chk("after t2");

    // 3: 000 / mark=0, upc changed mid-frame
    upc = 3'b000; mark = 1'b0;
    push_frame(upc, mark);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    run_frame(4, 6, 1, ab);
    @(negedge clk);

    // 4: start during a busy frame is ignored
    upc = 3'b011; mark = 1'b0;
    push_frame(upc, mark);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    run_frame(4, 10, 2, ab);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      idle_chk($sformatf("no 2nd frame%0d", i));
    end

    // 5: reset mid-frame, then a clean frame
    upc = 3'b010; mark = 1'b1;
    push_frame(upc, mark);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    run_frame(4, 13, 3, ab);
    chk("frame aborted", ab, 1'b1);
    @(negedge clk);
    idle_chk("held reset");
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      idle_chk($sformatf("post reset%0d", i));
    end
    upc = 3'b100; mark = 1'b1;
    push_frame(upc, mark);
    start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    run_frame(4, -1, 0, ab);
    @(negedge clk);

    // 6: continuous start, back-to-back frames, BIT_CYCLES=4 then 1
    upc = 3'b110; mark = 1'b0;
    for (int i = 0; i < 3; i++) push_frame(upc, mark);
    start4 = 1'b1;
    for (int f = 0; f < 3; f++) begin
      @(negedge clk);
      if (f == 2) start4 = 1'b0;
      run_frame(4, -1, 0, ab);
    end
    @(negedge clk);
    idle_chk("after b2b4");

    for (int i = 0; i < 3; i++) push_frame(upc, mark);
    start1 = 1'b1;
    for (int f = 0; f < 3; f++) begin
      @(negedge clk);
      if (f == 2) start1 = 1'b0;
      run_frame(1, -1, 0, ab);
    end
    @(negedge clk);
    chk("bc1 idle ready", ready1, 1'b1);
    chk("bc1 idle done", done1, 1'b0);
    chk("bc1 idle tx", tx1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
